time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 2000000, number of consecutive stable cycles that qualify a key level (20 ms at 100 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 50000000, number of cycles per blink half-period (0.5 s at 100 MHz).
REQ-003 SHALL have port clk, input, 1, system clock (100 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port key, input, 5, raw asynchronous buttons, active-high: [0] mode, [1] up, [2] down, [3] confirm, [4] cancel.
REQ-006 SHALL have ports cur_hour, cur_min, cur_sec, input, 8 each, binary live time from the timekeeper.
REQ-007 SHALL have ports set_hour, set_min, set_sec, output, 8 each, binary edited time, valid whenever load=1.
REQ-008 SHALL have port load, output, 1, one-cycle strobe commanding the timekeeper to take set_*.
REQ-009 SHALL have port editing, output, 1, high in every state except IDLE.
REQ-010 SHALL have port blink_mask, output, 8, per-digit blank request; bit7 = hour tens (leftmost) ... bit0 = second units; 1 = blank that digit.

Function
REQ-011 SHALL pass each key bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep a per-key debounced level; it changes only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles; any mismatch gap restarts that key's count.
REQ-013 SHALL generate a one-cycle press pulse per key on the 0->1 transition of its debounced level; release produces no pulse.
REQ-014 SHALL implement FSM states IDLE, EDIT_H, EDIT_M, EDIT_S.
REQ-015 SHALL, in IDLE on mode press, copy cur_hour/cur_min/cur_sec into the edit registers and enter EDIT_H; other presses in IDLE are ignored.
REQ-016 SHALL, on mode press, advance EDIT_H->EDIT_M->EDIT_S->EDIT_H.
REQ-017 SHALL, on up press, increment the selected field with wrap: hour 23->0, min/sec 59->0.
REQ-018 SHALL, on down press, decrement the selected field with wrap: hour 0->23, min/sec 0->59.
REQ-019 SHALL leave the field unchanged when up and down press pulses coincide.
REQ-020 SHALL, on confirm press in any EDIT state, drive load=1 for exactly one cycle with set_* equal to the edit registers, and return to IDLE.
REQ-021 SHALL, on cancel press in any EDIT state, return to IDLE without asserting load.
REQ-022 SHALL resolve same-cycle presses by priority cancel > confirm > mode > up/down; lower-priority presses that cycle are discarded.
REQ-023 SHALL drive set_* continuously from the edit registers; the values hold after load until the next IDLE->EDIT_H capture.
REQ-024 SHALL run a blink counter only while editing and toggle a phase bit every BLINK_CYCLES cycles; counter and phase clear to 0 on every state change and on every up/down change.
REQ-025 SHALL drive blink_mask = {phase,phase} on the two digits of the selected field (EDIT_H bits 7:6, EDIT_M 4:3, EDIT_S 1:0), 0 on all other bits, and all-0 in IDLE.

Reset
REQ-026 SHALL, while rst=1, set state IDLE, load=0, editing=0, blink_mask=0, set_*=0, edit registers 0, debounced levels 0, debounce/blink counters 0, synchronizers 0.
REQ-027 SHALL, on reset mid-edit, abandon the edit without a load pulse.
REQ-028 SHALL treat a key held through reset release as a new press once it qualifies per REQ-012.

Verification (DEB_CYCLES=4, BLINK_CYCLES=8)
REQ-029 SHALL check: key[1] glitch high for 3 cycles in EDIT_H -> no press, field unchanged; held 10 cycles -> exactly one increment.
REQ-030 SHALL check: cur=12:34:56, press mode -> EDIT_H, editing=1, edit regs 12/34/56; press down 13 times -> hour 23.
REQ-031 SHALL check: EDIT_M with min=59, press up -> 0, hour unchanged; mode -> EDIT_S, sec 0 press down -> 59.
REQ-032 SHALL check: confirm in EDIT_S with 08:05:59 -> load high one cycle, set_*=8/5/59, then IDLE, editing=0, blink_mask=0.
REQ-033 SHALL check: cancel and confirm pressed same cycle -> IDLE, load never asserted.
REQ-034 SHALL check: EDIT_M held 20 cycles -> blink_mask toggles 00000000/00011000 every 8 cycles starting 00000000; rst asserted mid-edit -> all outputs 0 next cycle.

Source files
------------

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Button-driven time-setting controller for a clock display. Five raw keys
// are synchronized, debounced and turned into press pulses; an FSM lets the
// user copy the live time, edit hour/minute/second with wrap-around, and
// either commit the result to the timekeeper (one-cycle load strobe) or
// abandon it. The selected field blinks while editing.
//
// Ports
//   clk                       system clock, rising edge
//   rst                       synchronous, active-high reset
//   key[4:0]                  raw buttons: 0 mode, 1 up, 2 down, 3 confirm, 4 cancel
//   cur_hour/cur_min/cur_sec  live binary time from the timekeeper
//   set_hour/set_min/set_sec  edited binary time, valid whenever load=1
//   load                      one-cycle strobe: timekeeper takes set_*
//   editing                   high in every state except IDLE
//   blink_mask[7:0]           per-digit blank request, bit7 = hour tens
// ---------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int DEB_CYCLES   = 2000000,
    parameter int BLINK_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic       load,
    output logic       editing,
    output logic [7:0] blink_mask
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, EDIT_S} state_t;

    // Wrapping +/-1 step on a field whose legal range is 0..max_v.
    function automatic logic [7:0] step_wrap(input logic [7:0] v,
                                             input logic [7:0] max_v,
                                             input logic       inc);
        if (inc) return (v >= max_v) ? 8'd0 : v + 8'd1;
        else     return (v == 8'd0)  ? max_v : v - 8'd1;
    endfunction

    // ---------------- synchronizer + debounce ----------------
    logic [4:0]    sync1, sync2;
    logic [4:0]    deb_level, deb_prev;
    logic [DW-1:0] deb_cnt [5];
    logic [4:0]    press;

    // NOTE: every clocked process uses non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb_level <= '0;
            deb_prev  <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            sync1    <= key;
            sync2    <= sync1;
            deb_prev <= deb_level;
            for (int i = 0; i < 5; i++) begin
                // Any cycle where the input agrees with the level restarts the count.
                if (sync2[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_cnt[i]   <= '0;
                    deb_level[i] <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign press = deb_level & ~deb_prev;

    wire p_mode    = press[0];
    wire p_up      = press[1];
    wire p_down    = press[2];
    wire p_confirm = press[3];
    wire p_cancel  = press[4];

    // ---------------- FSM + edit registers + blink ----------------
    state_t        state_q, state_n;
    logic [7:0]    hour_q, min_q, sec_q, hour_n, min_n, sec_n;
    logic          load_q, load_n;
    logic [BW-1:0] blink_cnt_q, blink_cnt_n;
    logic          phase_q, phase_n;
    logic          field_chg;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n     = state_q;
        hour_n      = hour_q;
        min_n       = min_q;
        sec_n       = sec_q;
        load_n      = 1'b0;
        field_chg   = 1'b0;
        blink_cnt_n = blink_cnt_q;
        phase_n     = phase_q;

        if (state_q == IDLE) begin
            if (p_mode) begin
                hour_n  = cur_hour;
                min_n   = cur_min;
                sec_n   = cur_sec;
                state_n = EDIT_H;
            end
        end else if (p_cancel) begin
            state_n = IDLE;
        end else if (p_confirm) begin
            load_n  = 1'b1;
            state_n = IDLE;
        end else if (p_mode) begin
            case (state_q)
                EDIT_H:  state_n = EDIT_M;
                EDIT_M:  state_n = EDIT_S;
                default: state_n = EDIT_H;
            endcase
        end else if (p_up ^ p_down) begin
            // Simultaneous up and down cancel each other out.
            field_chg = 1'b1;
            case (state_q)
                EDIT_H:  hour_n = step_wrap(hour_q, 8'd23, p_up);
                EDIT_M:  min_n  = step_wrap(min_q,  8'd59, p_up);
                default: sec_n  = step_wrap(sec_q,  8'd59, p_up);
            endcase
        end

        // Restart the blink on any visible change so the new value is shown at once.
        if (state_q == IDLE || state_n != state_q || field_chg) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_n = '0;
            phase_n     = ~phase_q;
        end else begin
            blink_cnt_n = blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            load_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            hour_q      <= hour_n;
            min_q       <= min_n;
            sec_q       <= sec_n;
            load_q      <= load_n;
            blink_cnt_q <= blink_cnt_n;
            phase_q     <= phase_n;
        end
    end

    always_comb begin
        blink_mask = 8'b0;
        case (state_q)
            EDIT_H:  blink_mask = {phase_q, phase_q, 6'b0};
            EDIT_M:  blink_mask = {3'b0, phase_q, phase_q, 3'b0};
            EDIT_S:  blink_mask = {6'b0, phase_q, phase_q};
            default: blink_mask = 8'b0;
        endcase
    end

    assign set_hour = hour_q;
    assign set_min  = min_q;
    assign set_sec  = sec_q;
    assign load     = load_q;
    assign editing  = (state_q != IDLE);

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed bench for time_set_ctrl with DEB_CYCLES=4, BLINK_CYCLES=8.
// Expected load transactions are queued when confirm is issued; a monitor
// pops and compares them whenever the DUT raises load. Edit state is
// observed through set_*, editing and blink_mask.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key;
    logic [7:0] cur_hour, cur_min, cur_sec;
    logic [7:0] set_hour, set_min, set_sec;
    logic       load, editing;
    logic [7:0] blink_mask;

    time_set_ctrl #(.DEB_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .key(key),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .load(load), .editing(editing), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int load_count = 0;
    logic [23:0] exp_q[$];
    logic        load_prev = 1'b0;

    localparam logic [4:0] K_MODE = 5'b00001, K_UP = 5'b00010, K_DOWN = 5'b00100,
                           K_CONF = 5'b01000, K_CANC = 5'b10000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every load must match the oldest queued expectation and last one cycle.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_count++;
            check("load_one_cycle", {31'b0, load_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                check("load_value", {8'b0, set_hour, set_min, set_sec}, {8'b0, exp_q.pop_front()});
            end
        end
        load_prev = load;
    end

    task automatic press(input logic [4:0] k);
        key = k;
        repeat (10) @(negedge clk);
        key = 5'b0;
        repeat (10) @(negedge clk);
    endtask

    function automatic logic [31:0] tval(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return {8'b0, h, m, s};
    endfunction

    function automatic logic [31:0] set_val();
        return {8'b0, set_hour, set_min, set_sec};
    endfunction

    task automatic wait_mask(input logic [7:0] m, input string name);
        int n = 0;
        while (blink_mask !== m && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check(name, {24'b0, blink_mask}, {24'b0, m});
    endtask

    initial begin
        rst = 1'b1;
        key = 5'b0;
        cur_hour = 8'd12; cur_min = 8'd34; cur_sec = 8'd56;
        repeat (3) @(negedge clk);
        // Reset state, sampled while rst is still high.
        check("rst_load",    {31'b0, load},     32'd0);
        check("rst_editing", {31'b0, editing},  32'd0);
        check("rst_mask",    {24'b0, blink_mask}, 32'd0);
        check("rst_set",     set_val(),         32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Non-mode keys in IDLE are ignored.
        press(K_UP);
        check("idle_ignore_edit", {31'b0, editing}, 32'd0);

        // Capture live time, then walk the hour down through 0 to 23.
        press(K_MODE);
        check("capture_editing", {31'b0, editing}, 32'd1);
        check("capture_value",   set_val(), tval(12, 34, 56));
        for (int i = 0; i < 13; i++) press(K_DOWN);
        check("hour_down_wrap", set_val(), tval(23, 34, 56));

        // 3-cycle glitch on up is filtered out; a 10-cycle hold counts once.
        key = K_UP;
        repeat (3) @(negedge clk);
        key = 5'b0;
        repeat (12) @(negedge clk);
        check("glitch_rejected", set_val(), tval(23, 34, 56));
        press(K_UP);
        check("hour_up_wrap", set_val(), tval(0, 34, 56));

        press(K_CANC);
        check("cancel_editing", {31'b0, editing}, 32'd0);
        check("cancel_holds_set", set_val(), tval(0, 34, 56));

        // Minute 59 -> 0, second 0 -> 59.
        cur_hour = 8'd8; cur_min = 8'd59; cur_sec = 8'd0;
        press(K_MODE);
        check("capture2_value", set_val(), tval(8, 59, 0));
        press(K_MODE);
        press(K_UP);
        check("min_up_wrap", set_val(), tval(8, 0, 0));
        press(K_MODE);
        press(K_DOWN);
        check("sec_down_wrap", set_val(), tval(8, 0, 59));

        // Full mode cycle back to EDIT_M, then minute up to 5.
        press(K_MODE);
        press(K_MODE);
        for (int i = 0; i < 5; i++) press(K_UP);
        check("min_up5", set_val(), tval(8, 5, 59));
        press(K_MODE);
        press(K_UP | K_DOWN);
        check("up_down_coincide", set_val(), tval(8, 5, 59));

        // Confirm in EDIT_S commits 08:05:59.
        exp_q.push_back({8'd8, 8'd5, 8'd59});
        press(K_CONF);
        check("confirm_load_count", load_count, 32'd1);
        check("confirm_editing", {31'b0, editing}, 32'd0);
        check("confirm_mask",    {24'b0, blink_mask}, 32'd0);
        check("confirm_set_hold", set_val(), tval(8, 5, 59));

        // Cancel beats confirm when both arrive together.
        press(K_MODE);
        press(K_CANC | K_CONF);
        check("canc_conf_editing", {31'b0, editing}, 32'd0);
        check("canc_conf_no_load", load_count, 32'd1);

        // Blink in EDIT_M: align on the start of an EDIT_H "blank" phase,
        // press mode, and observe the mask from the first EDIT_M cycle.
        press(K_MODE);
        wait_mask(8'h00, "blink_sync_low");
        wait_mask(8'hC0, "blink_sync_high");
        key = K_MODE;
        @(negedge clk);
        wait_mask(8'h00, "blink_enter_m");
        key = 5'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("blink_m_%0d", i), {24'b0, blink_mask},
                  ((i / 8) % 2 == 1) ? 32'h18 : 32'h00);
            @(negedge clk);
        end

        // Reset mid-edit with mode held through it.
        cur_hour = 8'd1; cur_min = 8'd2; cur_sec = 8'd3;
        rst = 1'b1;
        key = K_MODE;
        @(negedge clk);
        check("midrst_editing", {31'b0, editing}, 32'd0);
        check("midrst_mask",    {24'b0, blink_mask}, 32'd0);
        check("midrst_load",    {31'b0, load}, 32'd0);
        check("midrst_set",     set_val(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("held_through_rst_press", {31'b0, editing}, 32'd1);
        check("held_through_rst_value", set_val(), tval(1, 2, 3));
        key = 5'b0;
        repeat (12) @(negedge clk);

        check("final_load_count", load_count, 32'd1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
